pll_lock_monitor: RTL and testbench

Downstream companion of the PLL top. Consumes the PLL's asynchronous `locked` flag and produces a clean, synchronous, debounced reset for logic running off the PLL output clocks. Reset is held until `locked` has been stable for a programmable time. It is re-asserted for a minimum hold time on any loss of lock, and lock-loss events are counted for debug.

---
 rtl/pll_lock_monitor.sv | 167 ++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: turns the PLL's asynchronous locked flag into a debounced,
// synchronous reset for PLL-domain logic and counts lock-loss events.
// Optional build macro PLL_MON_TIMEOUT_EN adds a sticky lock-timeout flag
// (lock_err). Without it, lock_err is tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// WAIT  | reset held; qualifying locked_s for STABLE_CNT cycles
// RUN   | reset released; any locked_s low goes to LOST
// LOST  | reset held for HOLD_CNT cycles regardless of locked
// 2'b11 | illegal; recovers to WAIT on the next edge
module pll_lock_monitor #(
    parameter int STABLE_CNT  = 1000,
    parameter int HOLD_CNT    = 16,
    parameter int TIMEOUT_CNT = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       locked,
    input  logic       loss_clr,
    output logic       rst_out,
    output logic       rst_out_n,
    output logic       lock_ok,
    output logic [7:0] loss_cnt,
    output logic       lock_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_LOST = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_M1   = CNT_W'(HOLD_CNT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             locked_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       loss_cnt_q, loss_cnt_d;
    logic [7:0]       loss_base;
    logic             loss_evt;
    logic             rst_out_q, rst_out_d;
    logic             rst_out_n_q, rst_out_n_d;
    logic             lock_ok_q, lock_ok_d;

    assign locked_s = sync2_q;

    // Next-state, qualify/hold counter and loss-count update.
    always_comb begin
        sync1_d  = locked;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (locked_s) begin
                    if (cnt_q == STABLE_M1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_LOST;
                    cnt_d    = '0;
                    loss_evt = 1'b1;
                end
            end
            ST_LOST: begin
                if (cnt_q == HOLD_M1) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase

        // clear takes effect first so a coincident loss still counts as one
        loss_base  = loss_clr ? 8'd0 : loss_cnt_q;
        loss_cnt_d = (loss_evt && (loss_base != 8'hFF)) ? loss_base + 8'd1 : loss_base;

        rst_out_d   = (state_d != ST_RUN);
        rst_out_n_d = (state_d == ST_RUN);
        lock_ok_d   = (state_d == ST_RUN);
    end

    // Register state, counters, synchronizer and outputs; sys_rst wins.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            loss_cnt_q  <= 8'd0;
            rst_out_q   <= 1'b1;
            rst_out_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            rst_out_q   <= rst_out_d;
            rst_out_n_q <= rst_out_n_d;
            lock_ok_q   <= lock_ok_d;
        end
    end

`ifdef PLL_MON_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CNT);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             lock_err_q, lock_err_d;
    logic             tmo_run;

    // Timeout count only while staying in WAIT; any exit restarts it.
    always_comb begin
        tmo_run   = (state_q == ST_WAIT) && (state_d == ST_WAIT);
        tmo_cnt_d = '0;
        if (tmo_run) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
        lock_err_d = lock_err_q | (tmo_run && (tmo_cnt_d == TMO_MAX));
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmo_cnt_q  <= '0;
            lock_err_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_err = lock_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CNT > 0);
    assign lock_err       = 1'b0;
`endif

    assign rst_out   = rst_out_q;
    assign rst_out_n = rst_out_n_q;
    assign lock_ok   = lock_ok_q;
    assign loss_cnt  = loss_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor with STABLE_CNT=8, HOLD_CNT=4,
// TIMEOUT_CNT=32. Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, so "edge k" below is the k-th rising edge
// after the edge at which an input was changed.
module tb_pll_lock_monitor;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       locked;
    logic       loss_clr;
    logic       rst_out;
    logic       rst_out_n;
    logic       lock_ok;
    logic [7:0] loss_cnt;
    logic       lock_err;
    logic [1:0] state;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef PLL_MON_TIMEOUT_EN
    localparam logic TMO_EXP = 1'b1;
`else
    localparam logic TMO_EXP = 1'b0;
`endif

    pll_lock_monitor #(
        .STABLE_CNT (8),
        .HOLD_CNT   (4),
        .TIMEOUT_CNT(32),
        .CNT_W      (16)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .locked   (locked),
        .loss_clr (loss_clr),
        .rst_out  (rst_out),
        .rst_out_n(rst_out_n),
        .lock_ok  (lock_ok),
        .loss_cnt (loss_cnt),
        .lock_err (lock_err),
        .state    (state)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One-cycle lock drop from RUN; returns in RUN 15 edges after the drop.
    task automatic one_loss();
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(14);
    endtask

    initial begin
        sys_rst  = 1'b1;
        locked   = 1'b0;
        loss_clr = 1'b0;
        tick(3);
        check("rst_rst_out",   32'(rst_out),   32'd1);
        check("rst_rst_out_n", 32'(rst_out_n), 32'd0);
        check("rst_lock_ok",   32'(lock_ok),   32'd0);
        check("rst_loss_cnt",  32'(loss_cnt),  32'd0);
        check("rst_state",     32'(state),     32'd0);
        check("rst_lock_err",  32'(lock_err),  32'd0);

        // timeout: locked held low after reset release
        sys_rst = 1'b0;
        tick(31);
        check("tmo_edge31", 32'(lock_err), 32'd0);
        tick(1);
        check("tmo_edge32", 32'(lock_err), 32'(TMO_EXP));
        check("tmo_state",  32'(state),    32'd0);

        // clean lock: release at edge 10
        locked = 1'b1;
        tick(9);
        check("lock_e9_rst_out", 32'(rst_out), 32'd1);
        check("lock_e9_state",   32'(state),   32'd0);
        tick(1);
        check("lock_e10_rst_out",   32'(rst_out),   32'd0);
        check("lock_e10_rst_out_n", 32'(rst_out_n), 32'd1);
        check("lock_e10_lock_ok",   32'(lock_ok),   32'd1);
        check("lock_e10_state",     32'(state),     32'd1);
        check("lock_e10_loss_cnt",  32'(loss_cnt),  32'd0);
        check("lock_err_sticky",    32'(lock_err),  32'(TMO_EXP));

        // loss in RUN: one-cycle drop
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        check("loss_e2_rst_out", 32'(rst_out), 32'd0);
        check("loss_e2_state",   32'(state),   32'd1);
        tick(1);
        check("loss_e3_rst_out",  32'(rst_out),  32'd1);
        check("loss_e3_loss_cnt", 32'(loss_cnt), 32'd1);
        check("loss_e3_lock_ok",  32'(lock_ok),  32'd0);
        check("loss_e3_state",    32'(state),    32'd2);
        for (int e = 4; e <= 6; e++) begin
            tick(1);
            check($sformatf("loss_e%0d_state", e), 32'(state), 32'd2);
        end
        tick(1);
        check("loss_e7_state", 32'(state), 32'd0);
        tick(7);
        check("loss_e14_state",   32'(state),   32'd0);
        check("loss_e14_rst_out", 32'(rst_out), 32'd1);
        tick(1);
        check("loss_e15_state",   32'(state),   32'd1);
        check("loss_e15_rst_out", 32'(rst_out), 32'd0);

        // reset mid-RUN
        sys_rst = 1'b1;
        locked  = 1'b0;
        tick(1);
        check("mrst_rst_out",  32'(rst_out),  32'd1);
        check("mrst_lock_ok",  32'(lock_ok),  32'd0);
        check("mrst_state",    32'(state),    32'd0);
        check("mrst_loss_cnt", 32'(loss_cnt), 32'd0);
        check("mrst_lock_err", 32'(lock_err), 32'd0);
        sys_rst = 1'b0;
        tick(2);

        // glitchy lock: high 5, low 1, final rise at edge 6 -> release at 16
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(9);
        check("glitch_e15_rst_out", 32'(rst_out), 32'd1);
        tick(1);
        check("glitch_e16_rst_out", 32'(rst_out),  32'd0);
        check("glitch_loss_cnt",    32'(loss_cnt), 32'd0);

        // saturation
        for (int i = 0; i < 255; i++) one_loss();
        check("sat_255", 32'(loss_cnt), 32'd255);
        for (int i = 0; i < 5; i++) one_loss();
        check("sat_260",       32'(loss_cnt), 32'd255);
        check("sat_state",     32'(state),    32'd1);
        check("sat_lock_err",  32'(lock_err), 32'd0);

        // loss_clr coincident with a loss edge
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        loss_clr = 1'b1;
        tick(1);
        loss_clr = 1'b0;
        check("clr_with_loss", 32'(loss_cnt), 32'd1);
        tick(12);
        check("clr_relock_state", 32'(state), 32'd1);

        // loss_clr alone
        loss_clr = 1'b1;
        tick(1);
        loss_clr = 1'b0;
        check("clr_alone", 32'(loss_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
